// File: rtl/sme_match_drain.sv
// Scan controller for one string-matcher engine: reloads the flow's saved preamble,
// drains match indices into a 16-bit record stream with a terminator, and saves carry-over state.
module sme_match_drain #(
   parameter int FLOWS        = 16,
   parameter int FLOW_W       = 4,
   parameter int MAX_MATCHES  = 32,
   parameter int HOLDOFF      = 2,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [FLOW_W-1:0] cmd_flow_id,
   input  logic              cmd_restore,
   input  logic              pkt_done,
   output logic              reload,
   output logic [63:0]       preamble_state,
   input  logic              match_valid,
   input  logic [15:0]       match_index,
   output logic              next_index,
   input  logic [63:0]       last_bytes_state,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic              out_last,
   output logic              busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_SAVE  = 3'd4;
   localparam logic [2:0] S_TERM  = 3'd5;

   localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam int DC_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   logic [2:0]        state;
   logic [FLOW_W-1:0] flow_q;
   logic [15:0]       count;
   logic              overflow;
   logic              pkt_done_lat;
   logic [HO_W-1:0]   holdoff;
   logic [DC_W-1:0]   drain_cnt;

   // Valid bits are reset; the data half of each entry is meaningless until bit0 is set.
   logic [FLOWS-1:0]  tbl_vld;
   logic [63:1]       tbl_data [FLOWS];

   logic in_match_state;
   logic qualified;
   logic out_free;
   logic capture;
   logic overflow_hit;

   // Terminator word: overflow flag on top, record count below.
   function automatic logic [15:0] term_word(input logic ovf, input logic [15:0] cnt);
      return {ovf, cnt[14:0]};
   endfunction

   always_comb begin
      in_match_state = (state == S_SCAN) || (state == S_DRAIN);
      qualified      = match_valid && (holdoff == '0) && (state != S_LOAD);
      out_free       = !out_valid || out_ready;
      capture        = in_match_state && qualified && (count < 16'(MAX_MATCHES)) && out_free;
      overflow_hit   = in_match_state && qualified && (count == 16'(MAX_MATCHES));
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         flow_q         <= '0;
         count          <= '0;
         overflow       <= 1'b0;
         pkt_done_lat   <= 1'b0;
         holdoff        <= '0;
         drain_cnt      <= '0;
         tbl_vld        <= '0;
         reload         <= 1'b0;
         next_index     <= 1'b0;
         preamble_state <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_last       <= 1'b0;
      end else begin
         reload     <= 1'b0;
         next_index <= 1'b0;

         if (out_valid && out_ready)
            out_valid <= 1'b0;

         // Holdoff covers the cycles where the engine has not yet reacted to a pop.
         if (capture)
            holdoff <= HO_W'(HOLDOFF);
         else if (holdoff != '0)
            holdoff <= holdoff - 1'b1;

         if (pkt_done && (state == S_LOAD || state == S_SCAN || state == S_DRAIN))
            pkt_done_lat <= 1'b1;

         if (capture) begin
            out_data   <= match_index;
            out_last   <= 1'b0;
            out_valid  <= 1'b1;
            next_index <= 1'b1;
            count      <= count + 16'd1;
         end

         if (overflow_hit)
            overflow <= 1'b1;

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  flow_q         <= cmd_flow_id;
                  count          <= '0;
                  overflow       <= 1'b0;
                  pkt_done_lat   <= 1'b0;
                  drain_cnt      <= '0;
                  preamble_state <= cmd_restore ?
                                    {tbl_data[cmd_flow_id], tbl_vld[cmd_flow_id]} : 64'h0;
                  reload         <= 1'b1;
                  state          <= S_LOAD;
               end
            end
            S_LOAD: begin
               state <= S_SCAN;
            end
            S_SCAN: begin
               drain_cnt <= '0;
               if (pkt_done_lat)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               // Any capture restarts the quiet-period count.
               if (capture)
                  drain_cnt <= '0;
               else if (drain_cnt == DC_W'(DRAIN_CYCLES - 1)) begin
                  drain_cnt <= '0;
                  state     <= S_SAVE;
               end else
                  drain_cnt <= drain_cnt + 1'b1;
            end
            S_SAVE: begin
               tbl_vld[flow_q] <= last_bytes_state[0];
               state           <= S_TERM;
            end
            S_TERM: begin
               if (out_free) begin
                  out_data  <= term_word(overflow, count);
                  out_last  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_SAVE)
         tbl_data[flow_q] <= last_bytes_state[63:1];
   end

endmodule

// File: tb/tb_sme_match_drain.sv
// Directed bench for sme_match_drain: an engine model feeds match queues, a scoreboard
// predicts records/terminators per scan, and one compare process checks every cycle.
module tb_sme_match_drain;

   localparam int MAXM = 32;
   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_flow_id = '0;
   logic        cmd_restore = 1'b0;
   logic        pkt_done = 1'b0;
   logic        reload;
   logic [63:0] preamble_state;
   logic        match_valid;
   logic [15:0] match_index;
   logic        next_index;
   logic [63:0] last_bytes_state = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   sme_match_drain #(
      .FLOWS(16), .FLOW_W(4), .MAX_MATCHES(MAXM), .HOLDOFF(HOLD), .DRAIN_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_flow_id(cmd_flow_id), .cmd_restore(cmd_restore), .pkt_done(pkt_done),
      .reload(reload), .preamble_state(preamble_state), .match_valid(match_valid),
      .match_index(match_index), .next_index(next_index),
      .last_bytes_state(last_bytes_state), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // Engine model: a list of pending indices, popped when next_index is seen.
   logic [15:0] eng_mem [256];
   int          eng_n = 0;
   int          eng_rd = 0;
   logic        eng_flush = 1'b0;

   assign match_valid = (eng_rd < eng_n);
   assign match_index = eng_mem[eng_rd & 255];

   always @(posedge clk) begin
      if (eng_flush)
         eng_rd <= eng_n;
      else if (next_index && (eng_rd < eng_n))
         eng_rd <= eng_rd + 1;
   end

   // Scoreboard of expected output beats.
   logic [15:0] exp_data [256];
   bit          exp_last [256];
   logic [15:0] exp_lit  [256];
   int          exp_nidx [256];
   int          exp_wr = 0;
   int          exp_rd = 0;

   // Model of the per-flow table; mask marks which bits are defined.
   logic [63:0] mtab  [16];
   logic [63:0] mmask [16];
   logic [63:0] exp_pre  = '0;
   logic [63:0] exp_mask = '1;
   logic [63:0] exp_plit = '0;

   int total = 0;
   int bad = 0;
   int term_seen = 0;
   int tmo_events = 0;
   int terms_expected = 0;
   bit done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Compare process: samples on the falling edge, away from the active edge.
   int          cyc = 0;
   bit          rst_prev = 1'b0;
   bit          acc_pend = 1'b0;
   bit          hold_pend = 1'b0;
   logic [15:0] hold_data;
   logic        hold_last;
   int          last_ni = -100;
   int          nidx_cnt = 0;
   int          tmo_seen = 0;
   bit          final_done = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (tmo_events != tmo_seen) begin
         chk("wait_timeout", 64'd1, 64'd0);
         tmo_seen = tmo_events;
      end
      if (rst) begin
         if (rst_prev) begin
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_reload", {63'd0, reload}, 64'd0);
            chk("rst_next_index", {63'd0, next_index}, 64'd0);
            chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
         end
         acc_pend  = 1'b0;
         hold_pend = 1'b0;
         last_ni   = -100;
         nidx_cnt  = 0;
      end else begin
         chk("reload", {63'd0, reload}, {63'd0, acc_pend});
         if (acc_pend) begin
            chk("preamble", preamble_state & exp_mask, exp_pre & exp_mask);
            chk("preamble_literal", preamble_state & exp_mask, exp_plit & exp_mask);
         end
         acc_pend = cmd_valid && cmd_ready;

         if (hold_pend) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {48'd0, out_data}, {48'd0, hold_data});
            chk("hold_last", {63'd0, out_last}, {63'd0, hold_last});
         end
         hold_pend = out_valid && !out_ready;
         hold_data = out_data;
         hold_last = out_last;

         if (next_index) begin
            chk("next_index_gap", {63'd0, (cyc - last_ni) >= HOLD + 1}, 64'd1);
            last_ni = cyc;
            nidx_cnt++;
         end

         if (out_valid && out_ready) begin
            if (exp_rd >= exp_wr) begin
               chk("unexpected_beat", {47'd0, out_last, out_data}, 64'h0);
            end else begin
               chk("out_data", {48'd0, out_data}, {48'd0, exp_data[exp_rd & 255]});
               chk("out_last", {63'd0, out_last}, {63'd0, exp_last[exp_rd & 255]});
               if (exp_last[exp_rd & 255]) begin
                  chk("term_literal", {48'd0, out_data}, {48'd0, exp_lit[exp_rd & 255]});
                  chk("next_index_count", 64'(nidx_cnt), 64'(exp_nidx[exp_rd & 255]));
                  nidx_cnt = 0;
                  term_seen++;
               end
               exp_rd++;
            end
         end
      end
      if (done && !final_done) begin
         chk("all_beats_seen", 64'(exp_rd), 64'(exp_wr));
         final_done = 1'b1;
      end
      rst_prev = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input bit l, input logic [15:0] lit, input int ni);
      exp_data[exp_wr & 255] = d;
      exp_last[exp_wr & 255] = l;
      exp_lit[exp_wr & 255]  = lit;
      exp_nidx[exp_wr & 255] = ni;
      exp_wr++;
   endtask

   task automatic wait_cmd_ready();
      for (int i = 0; i < 200 && !cmd_ready; i++) tick();
      if (!cmd_ready) tmo_events++;
   endtask

   task automatic issue_cmd(input logic [3:0] flow, input bit restore);
      wait_cmd_ready();
      cmd_flow_id = flow;
      cmd_restore = restore;
      cmd_valid   = 1'b1;
      tick();
      cmd_valid   = 1'b0;
   endtask

   // One scan: n matches base, base+16, ...; tlit/plit are the hand-computed terminator and preamble.
   task automatic scan(input logic [3:0] flow, input bit restore, input int n,
                       input logic [15:0] base, input logic [63:0] lbs,
                       input logic [15:0] tlit, input logic [63:0] plit,
                       input int bp, input int pdly);
      int nrec;
      nrec = (n > MAXM) ? MAXM : n;
      exp_pre  = restore ? mtab[flow] : 64'h0;
      exp_mask = restore ? mmask[flow] : '1;
      exp_plit = plit;
      for (int i = 0; i < nrec; i++) push(base + 16'(i * 16), 1'b0, 16'h0, 0);
      push({n > MAXM, 15'(nrec)}, 1'b1, tlit, nrec);
      terms_expected++;
      for (int i = 0; i < n; i++) eng_mem[(eng_n + i) & 255] = base + 16'(i * 16);
      eng_n = eng_n + n;
      last_bytes_state = lbs;
      mtab[flow]  = lbs;
      mmask[flow] = '1;
      issue_cmd(flow, restore);
      if (bp > 0) out_ready = 1'b0;
      for (int i = 0; i < pdly; i++) begin
         if (i == bp) out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b1;
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      for (int i = 0; i < 2000 && term_seen < terms_expected; i++) tick();
      if (term_seen < terms_expected) tmo_events++;
      eng_flush = 1'b1;
      tick();
      eng_flush = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mtab[i]  = 64'h0;
         mmask[i] = 64'h1;
      end
      for (int i = 0; i < 256; i++) eng_mem[i] = 16'h0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      scan(4'd3, 1'b0, 0,  16'h0000, 64'h1122334455667701, 16'h0000, 64'h0, 0, 5);
      scan(4'd7, 1'b0, 3,  16'h0010, 64'hA5A5A5A5A5A5A500, 16'h0003, 64'h0, 0, 5);
      scan(4'd3, 1'b1, 0,  16'h0000, 64'h0102030405060701, 16'h0000,
           64'h1122334455667701, 0, 5);
      scan(4'd9, 1'b0, 2,  16'h0100, 64'hCAFEF00DCAFEF001, 16'h0002, 64'h0, 10, 25);
      scan(4'd2, 1'b0, 40, 16'h1000, 64'h0F0F0F0F0F0F0F01, 16'h8020, 64'h0, 0, 5);

      // Reset in the middle of DRAIN: nothing is pushed, so any beat is flagged.
      exp_pre  = 64'h0;
      exp_mask = '1;
      exp_plit = 64'h0;
      last_bytes_state = 64'hDEADBEEFDEADBE01;
      issue_cmd(4'd3, 1'b0);
      repeat (3) tick();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mtab[i]  = 64'h0;
         mmask[i] = 64'h1;
      end
      tick();

      scan(4'd3, 1'b1, 1, 16'h0ABC, 64'h7766554433221101, 16'h0001, 64'h0, 0, 5);

      repeat (3) tick();
      done = 1'b1;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
